// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch core: FSM state encoding
// and BCD digit limits used by the digit counters.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam int             BCD_W        = 4;
    localparam logic [BCD_W-1:0] DIG_MAX_TENS = 4'd5;
    localparam logic [BCD_W-1:0] DIG_MAX_DEC  = 4'd9;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One stage of the cascaded BCD counter. Counts 0..MAX on each enable and
// raises carry in the same cycle it wraps, so the next stage advances on
// the same clock edge. A synchronous clear zeroes the digit and wins over
// the enable.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX = DIG_MAX_DEC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    assign carry = en && (digit == MAX);

    // Digit register: clear has priority, otherwise step and wrap at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (en) begin
            if (digit == MAX) begin
                digit <= '0;
            end else begin
                digit <= digit + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch core: button synchronisers with falling-edge detection, an
// IDLE/RUN/STOP control FSM, a 1/100 s divider and four cascaded BCD
// digits (00.00 .. 59.99).
// Optional lap display is enabled by defining STOPWATCH_LAP_EN; without it
// lap_n is ignored and the digit outputs are always live.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int               DIV_W    = 19,
    parameter logic [DIV_W-1:0] DIV_TERM = 19'd499999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strt_stp_n,
    input  logic       clr_n,
    input  logic       lap_n,
    output logic [3:0] dig0,
    output logic [3:0] dig1,
    output logic [3:0] dig2,
    output logic [3:0] dig3,
    output logic       hundrethSec,
    output logic       running
);

    logic [1:0]       btn_sync1;
    logic [1:0]       btn_sync2;
    logic [1:0]       btn_prev;
    logic             strt_press;
    logic             clr_press;

    state_t           state_q;
    state_t           state_d;

    logic [DIV_W-1:0] divcnt;
    logic             tick;

    logic [BCD_W-1:0] live0;
    logic [BCD_W-1:0] live1;
    logic [BCD_W-1:0] live2;
    logic [BCD_W-1:0] live3;
    logic             carry0;
    logic             carry1;
    logic             carry2;
    logic             carry3_unused;

    // Two-flop synchroniser plus a previous-value flop for start/stop (bit 0)
    // and clear (bit 1); all preset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_sync1 <= 2'b11;
            btn_sync2 <= 2'b11;
            btn_prev  <= 2'b11;
        end else begin
            btn_sync1 <= {clr_n, strt_stp_n};
            btn_sync2 <= btn_sync1;
            btn_prev  <= btn_sync2;
        end
    end

    assign strt_press = !btn_sync2[0] && btn_prev[0];
    assign clr_press  = !btn_sync2[1] && btn_prev[1];

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: clear beats start/stop, start/stop toggles run.
    always_comb begin
        state_d = state_q;
        if (clr_press) begin
            state_d = IDLE;
        end else if (strt_press) begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     state_d = STOP;
                STOP:    state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    assign tick        = (state_q == RUN) && (divcnt == DIV_TERM);
    assign hundrethSec = tick;
    assign running     = (state_q == RUN);

    // Divider: counts in RUN, holds the partial period in STOP, idles at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divcnt <= '0;
        end else if (clr_press) begin
            divcnt <= '0;
        end else begin
            case (state_q)
                RUN:     divcnt <= tick ? '0 : divcnt + DIV_W'(1);
                STOP:    divcnt <= divcnt;
                default: divcnt <= '0;
            endcase
        end
    end

    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_hundredths (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_press),
        .en    (tick),
        .digit (live0),
        .carry (carry0)
    );

    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_tenths (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_press),
        .en    (carry0),
        .digit (live1),
        .carry (carry1)
    );

    bcd_digit_cnt #(.MAX(DIG_MAX_DEC)) u_sec_ones (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_press),
        .en    (carry1),
        .digit (live2),
        .carry (carry2)
    );

    bcd_digit_cnt #(.MAX(DIG_MAX_TENS)) u_sec_tens (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_press),
        .en    (carry2),
        .digit (live3),
        .carry (carry3_unused)
    );

`ifdef STOPWATCH_LAP_EN
    logic                 lap_sync1;
    logic                 lap_sync2;
    logic                 lap_prev;
    logic                 lap_press;
    logic                 lap_hold;
    logic [4*BCD_W-1:0]   lap_snap;

    // Lap button synchroniser and edge flop, preset to released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_sync1 <= 1'b1;
            lap_sync2 <= 1'b1;
            lap_prev  <= 1'b1;
        end else begin
            lap_sync1 <= lap_n;
            lap_sync2 <= lap_sync1;
            lap_prev  <= lap_sync2;
        end
    end

    assign lap_press = !lap_sync2 && lap_prev;

    // Lap hold toggles only while running; entering hold snapshots the
    // live count, and clear always returns to the live display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold <= 1'b0;
            lap_snap <= '0;
        end else if (clr_press) begin
            lap_hold <= 1'b0;
        end else if (lap_press && (state_q == RUN)) begin
            lap_hold <= !lap_hold;
            if (!lap_hold) begin
                lap_snap <= {live3, live2, live1, live0};
            end
        end
    end

    assign dig0 = lap_hold ? lap_snap[3:0]   : live0;
    assign dig1 = lap_hold ? lap_snap[7:4]   : live1;
    assign dig2 = lap_hold ? lap_snap[11:8]  : live2;
    assign dig3 = lap_hold ? lap_snap[15:12] : live3;
`else
    logic lap_unused;

    assign lap_unused = lap_n;
    assign dig0       = live0;
    assign dig1       = live1;
    assign dig2       = live2;
    assign dig3       = live3;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with a small divider (tick every 5 cycles).
// A reference model tracks elapsed hundredths as a plain integer and the
// position inside the current 1/100 s period; every predicted tick pushes
// the expected elapsed time into a queue that a separate monitor pops
// whenever the DUT raises hundrethSec.
module tb_stopwatch_ctrl;

    localparam int DIV_W = 19;
    localparam int TERM  = 4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       strt_stp_n = 1'b1;
    logic       clr_n      = 1'b1;
    logic       lap_n      = 1'b1;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic       hundrethSec;
    logic       running;

    stopwatch_ctrl #(
        .DIV_W    (DIV_W),
        .DIV_TERM (19'(TERM))
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .strt_stp_n  (strt_stp_n),
        .clr_n       (clr_n),
        .lap_n       (lap_n),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .hundrethSec (hundrethSec),
        .running     (running)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: m_state 0 = idle, 1 = running, 2 = stopped.
    int m_state = 0;
    int m_count = 0;
    int m_phase = 0;
    int strt_cd = 0;
    int clr_cd  = 0;
    int sb_q[$];

    function automatic logic [15:0] bcd_of(int c);
        return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one clock edge, update the model for that edge and check.
    task automatic step();
        bit was_run;
        bit tick_now;
        bit s_ev;
        bit c_ev;
        @(posedge clk);
        #1;
        was_run  = (m_state == 1);
        tick_now = was_run && (m_phase == TERM);
        if (was_run) m_phase = tick_now ? 0 : m_phase + 1;
        if (tick_now) m_count = (m_count + 1) % 6000;
        s_ev = 1'b0;
        c_ev = 1'b0;
        if (strt_cd > 0) begin
            strt_cd--;
            s_ev = (strt_cd == 0);
        end
        if (clr_cd > 0) begin
            clr_cd--;
            c_ev = (clr_cd == 0);
        end
        if (c_ev) begin
            m_state = 0;
            m_count = 0;
            m_phase = 0;
        end else if (s_ev) begin
            m_state = (m_state == 1) ? 2 : 1;
        end
        if (tick_now) sb_q.push_back(m_count);
        checkOutput("running", running, (m_state == 1));
        checkOutput("tick", hundrethSec, (m_state == 1) && (m_phase == TERM));
        checkOutput("digits", {dig3, dig2, dig1, dig0}, bcd_of(m_count));
    endtask

    // Press the selected buttons, hold them, release and let them settle.
    task automatic applyStimulus(bit press_strt, bit press_clr, int hold);
        if (press_strt) begin
            strt_stp_n = 1'b0;
            strt_cd    = 3;
        end
        if (press_clr) begin
            clr_n  = 1'b0;
            clr_cd = 3;
        end
        repeat (hold) step();
        strt_stp_n = 1'b1;
        clr_n      = 1'b1;
        repeat (4) step();
    endtask

    task automatic run_until_count(int target, int budget);
        int n = 0;
        while (m_count != target && n < budget) begin
            step();
            n++;
        end
        if (m_count != target) begin
            checks++;
            errors++;
            $display("[TB] FAIL run_until: count %0d, expected %0d within %0d cycles", m_count, target, budget);
        end
    endtask

    // Asynchronous reset pulse asserted between clock edges.
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        checkOutput("async_rst_running", running, 1'b0);
        checkOutput("async_rst_tick", hundrethSec, 1'b0);
        m_state = 0;
        m_count = 0;
        m_phase = 0;
        strt_cd = 0;
        clr_cd  = 0;
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: on each DUT tick, the digits after the next edge must match
    // the oldest predicted elapsed time.
    initial begin
        int expv;
        forever begin
            @(negedge clk);
            if (rst_n && hundrethSec) begin
                @(negedge clk);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got digits 0x%0h, expected no tick (queue empty)", {dig3, dig2, dig1, dig0});
                end else begin
                    expv = sb_q.pop_front();
                    checkOutput("sb_digits", {dig3, dig2, dig1, dig0}, bcd_of(expv));
                end
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int op;
        #12;
        checkOutput("reset_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
        checkOutput("reset_running", running, 1'b0);
        checkOutput("reset_tick", hundrethSec, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        $display("[TB] held start/stop from idle");
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("held_no_toggle", running, 1'b1);

        $display("[TB] async reset mid-run");
        while (m_phase != 2) step();
        do_reset();
        step();

        $display("[TB] run to 00.50, stop, hold, resume");
        applyStimulus(1'b1, 1'b0, 1);
        run_until_count(50, 1000);
        applyStimulus(1'b1, 1'b0, 1);
        repeat (100) step();
        checkOutput("stop_hold_digits", {dig3, dig2, dig1, dig0}, 16'h0050);
        checkOutput("stop_hold_running", running, 1'b0);
        applyStimulus(1'b1, 1'b0, 1);
        run_until_count(52, 100);

        $display("[TB] clear, run to 59.99 and wrap");
        applyStimulus(1'b0, 1'b1, 1);
        applyStimulus(1'b1, 1'b0, 1);
        run_until_count(5999, 40000);
        checkOutput("full_scale", {dig3, dig2, dig1, dig0}, 16'h5999);
        run_until_count(0, 10);
        checkOutput("full_wrap", {dig3, dig2, dig1, dig0}, 16'h0000);
        checkOutput("wrap_running", running, 1'b1);

        $display("[TB] clear and start/stop together while running");
        run_until_count(23, 200);
        applyStimulus(1'b1, 1'b1, 3);
        checkOutput("clr_wins_running", running, 1'b0);
        checkOutput("clr_wins_digits", {dig3, dig2, dig1, dig0}, 16'h0000);

        $display("[TB] randomized button sequences");
        repeat (40) begin
            op = $urandom_range(0, 3);
            case (op)
                0: applyStimulus(1'b1, 1'b0, $urandom_range(1, 20));
                1: repeat ($urandom_range(1, 60)) step();
                2: applyStimulus(1'b0, 1'b1, $urandom_range(1, 5));
                default: applyStimulus(1'b1, 1'b1, $urandom_range(1, 5));
            endcase
        end

        repeat (10) step();
        checkOutput("sb_drain", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
